// File: rtl/secure_reg_access_ctrl_if.sv
// secure_reg_access_ctrl_if
//   Request/response channel between a requester and the secure register
//   access controller.
//   master : drives req_valid/req_write/req_tid/req_wdata and rsp_ready
//   slave  : drives req_ready and rsp_valid/rsp_rdata/rsp_err
interface secure_reg_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [TID_WIDTH-1:0]  req_tid;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_tid, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_tid, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/secure_reg_access_ctrl.sv
// secure_reg_access_ctrl
//   Sequencer in front of the thread-gated secure register. Accepts one
//   thread-tagged request at a time, lets only thread 0 reach the register
//   (single-cycle access/write strobes), and returns read data / error over
//   a valid/ready response channel.
//
//   Optional feature macro: SECREG_LOCKOUT_EN
//     defined   : MAX_VIOL consecutive unauthorized requests lock the port
//                 for LOCK_CYCLES cycles after the last error response.
//     undefined : no violation tracking, locked_o tied 0.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   bus (slave)       request/response channel
//   reg_access_en_o   access strobe to register
//   reg_wr_en_o       write strobe to register
//   reg_thread_id_o   0 only during an authorized access
//   reg_data_in_o     write data to register (0 outside strobe cycle)
//   reg_data_out_i    register read data, valid one cycle after strobe
//   locked_o          port in lockout
module secure_reg_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int TID_WIDTH   = 4,
  parameter int MAX_VIOL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  secure_reg_access_ctrl_if.slave bus,
  output logic                  reg_access_en_o,
  output logic                  reg_wr_en_o,
  output logic                  reg_thread_id_o,
  output logic [DATA_WIDTH-1:0] reg_data_in_o,
  input  logic [DATA_WIDTH-1:0] reg_data_out_i,
  output logic                  locked_o
);

  if (MAX_VIOL < 1 || LOCK_CYCLES < 1) begin : g_bad_param
    $error("secure_reg_access_ctrl: MAX_VIOL and LOCK_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
`ifdef SECREG_LOCKOUT_EN
    , S_LOCK
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;

`ifdef SECREG_LOCKOUT_EN
  localparam int VW = $clog2(MAX_VIOL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [VW-1:0] MAXV      = VW'(MAX_VIOL);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES - 1);

  logic [VW-1:0] viol_q, viol_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  // req_ready_q is only ever high while in IDLE (it tracks state_d), and is
  // held low for the whole reset assertion.
  assign accept = bus.req_valid && req_ready_q;

  always_comb begin
    state_d = state_q;
`ifdef SECREG_LOCKOUT_EN
    viol_d     = viol_q;
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.req_tid == '0) begin
            state_d = S_ISSUE;
`ifdef SECREG_LOCKOUT_EN
            viol_d  = '0;
`endif
          end else begin
            state_d = S_RESP;
`ifdef SECREG_LOCKOUT_EN
            if (viol_q != MAXV) viol_d = viol_q + 1'b1;
`endif
          end
        end
      end
      S_ISSUE:   state_d = wr_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
`ifdef SECREG_LOCKOUT_EN
          if (viol_q == MAXV) begin
            state_d    = S_LOCK;
            lock_cnt_d = LOCK_INIT;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef SECREG_LOCKOUT_EN
      S_LOCK: begin
        if (lock_cnt_q == '0) begin
          state_d = S_IDLE;
          viol_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
`ifdef SECREG_LOCKOUT_EN
      viol_q      <= '0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == S_IDLE);
`ifdef SECREG_LOCKOUT_EN
      viol_q      <= viol_d;
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  // Request latch and read capture. rdata_q is cleared at acceptance so
  // writes and rejected requests respond with zero data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state_q == S_IDLE && accept) begin
      wr_q    <= bus.req_write;
      err_q   <= (bus.req_tid != '0);
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      rdata_q <= reg_data_out_i;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;

  assign reg_access_en_o = (state_q == S_ISSUE);
  assign reg_wr_en_o     = (state_q == S_ISSUE) && wr_q;
  assign reg_thread_id_o = (state_q != S_ISSUE);
  assign reg_data_in_o   = (state_q == S_ISSUE) ? wdata_q : '0;

`ifdef SECREG_LOCKOUT_EN
  assign locked_o = (state_q == S_LOCK);
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// tb_secure_reg_access_ctrl
//   Self-checking bench for secure_reg_access_ctrl. The bench plays the
//   secure register itself and keeps a transaction-level model: expected
//   register contents, a violation tally and per-request response latency.
module tb_secure_reg_access_ctrl;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int MAXV = 3;
  localparam int LOCKC = 16;
`ifdef SECREG_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_access_en, reg_wr_en, reg_thread_id, locked;
  logic [DW-1:0] reg_data_in;
  logic [DW-1:0] reg_store = '0;
  logic [DW-1:0] reg_rd = '0;

  int errors = 0;
  int checks = 0;

  // model state
  logic [DW-1:0] exp_reg = '0;
  int            viol = 0;

  secure_reg_access_ctrl_if #(.DATA_WIDTH(DW), .TID_WIDTH(TW)) bus ();

  secure_reg_access_ctrl #(
    .DATA_WIDTH(DW), .TID_WIDTH(TW), .MAX_VIOL(MAXV), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .reg_access_en_o (reg_access_en),
    .reg_wr_en_o     (reg_wr_en),
    .reg_thread_id_o (reg_thread_id),
    .reg_data_in_o   (reg_data_in),
    .reg_data_out_i  (reg_rd),
    .locked_o        (locked)
  );

  always #5 clk = ~clk;

  // Behaves like the thread-gated register: stores on authorized write
  // strobes, presents read data one cycle after an authorized read strobe.
  always @(posedge clk) begin
    if (reg_access_en && !reg_thread_id) begin
      if (reg_wr_en) reg_store <= reg_data_in;
      else           reg_rd    <= reg_store;
    end
  end

  // Issues one request from IDLE (called at a negedge) and checks every
  // cycle up to the point the port is ready again. hold = cycles rsp_ready
  // stays low once the response is up.
  task automatic run_req(input logic wr, input logic [TW-1:0] tid,
                         input logic [DW-1:0] wd, input int hold);
    logic          auth, s, lock_exp;
    logic [DW-1:0] exp_rd;
    logic [5:0]    got, exp;
    int            lat;
    auth   = (tid == '0);
    lat    = !auth ? 1 : (wr ? 2 : 3);
    exp_rd = (auth && !wr) ? exp_reg : '0;

    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle got=%b exp=1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_tid = tid; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = $urandom_range(0, 1) == 1;
    bus.req_tid = TW'($urandom); bus.req_wdata = $urandom;

    if (auth) begin
      viol = 0;
      if (wr) exp_reg = wd;
    end else if (viol < MAXV) viol++;

    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      s   = auth && (k == 1);
      got = {bus.rsp_valid, bus.req_ready, reg_access_en, reg_wr_en, reg_thread_id, locked};
      exp = {1'b0, 1'b0, s, s & wr, ~s, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pre_rsp_ctrl cyc=%0d got=%b exp=%b", k, got, exp);
      end
      checks++;
      if (reg_data_in !== (s ? wd : '0)) begin
        errors++; $display("FAIL reg_data_in cyc=%0d got=%h exp=%h", k, reg_data_in, s ? wd : '0);
      end
    end

    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      got = {bus.rsp_valid, bus.req_ready, reg_access_en, reg_wr_en, reg_thread_id, locked};
      checks++;
      if (got !== 6'b100010) begin
        errors++; $display("FAIL rsp_ctrl lat=%0d h=%0d got=%b exp=100010", lat, h, got);
      end
      checks++;
      if (bus.rsp_err !== ~auth || bus.rsp_rdata !== exp_rd) begin
        errors++; $display("FAIL rsp_data err=%b rdata=%h exp_err=%b exp_rdata=%h",
                           bus.rsp_err, bus.rsp_rdata, ~auth, exp_rd);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    lock_exp = LOCK_EN && (viol == MAXV);
    if (lock_exp) begin
      viol = 0;
      for (int c = 0; c < LOCKC; c++) begin
        checks++;
        if ({locked, bus.req_ready, bus.rsp_valid} !== 3'b100) begin
          errors++; $display("FAIL lock_window c=%0d locked=%b req_ready=%b rsp_valid=%b",
                             c, locked, bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({locked, bus.req_ready, bus.rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL ready_after_rsp locked=%b req_ready=%b rsp_valid=%b",
                         locked, bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_tid = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, reg_access_en, reg_wr_en,
         reg_thread_id, locked} !== 7'b0000010 || bus.rsp_rdata !== '0 || reg_data_in !== '0) begin
      errors++; $display("FAIL reset_vals rdy=%b vld=%b err=%b acc=%b wr=%b tid=%b lck=%b rd=%h din=%h exp=0000010/0/0",
        bus.req_ready, bus.rsp_valid, bus.rsp_err, reg_access_en, reg_wr_en,
        reg_thread_id, locked, bus.rsp_rdata, reg_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_reset rdy=%b vld=%b exp=1/0", bus.req_ready, bus.rsp_valid);
    end
    viol = 0;
  endtask

  task automatic test_write();
    run_req(1'b1, 4'd0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_read();
    run_req(1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_violation();
    run_req(1'b1, 4'd5, 32'h12345678, 0);
    run_req(1'b0, 4'd0, 32'h0, 0);  // register untouched by rejected write
  endtask

  task automatic test_backpressure();
    run_req(1'b0, 4'd0, 32'h0, 4);
  endtask

  task automatic test_lockout();
    run_req(1'b1, 4'd2, 32'h1, 0);
    run_req(1'b0, 4'd2, 32'h2, 0);
    run_req(1'b1, 4'd2, 32'h3, 0);  // third in a row: lockout when enabled
    run_req(1'b1, 4'd0, 32'hA5A5_0F0F, 0);
    run_req(1'b1, 4'd2, 32'h4, 0);
    run_req(1'b0, 4'd7, 32'h5, 0);
    run_req(1'b0, 4'd0, 32'h0, 0);  // clears the tally
    run_req(1'b1, 4'd2, 32'h6, 1);
    checks++;
    if (locked !== 1'b0 || viol != 1) begin
      errors++; $display("FAIL no_lock_after_clear locked=%b tally=%0d exp=0/1", locked, viol);
    end
  endtask

  task automatic test_reset_in_capture();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_tid = '0; bus.req_wdata = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    viol = 0;
    @(negedge clk);  // ISSUE
    @(negedge clk);  // CAPTURE
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, reg_access_en, reg_wr_en,
         reg_thread_id, locked} !== 7'b0000010 || bus.rsp_rdata !== '0 || reg_data_in !== '0) begin
      errors++; $display("FAIL reset_mid_capture rdy=%b vld=%b acc=%b tid=%b rd=%h exp=0/0/0/1/0",
        bus.req_ready, bus.rsp_valid, reg_access_en, reg_thread_id, bus.rsp_rdata);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL dropped_rsp c=%0d vld=%b rdy=%b exp=0/1", c, bus.rsp_valid, bus.req_ready);
      end
    end
    run_req(1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [TW-1:0] tid;
    for (int n = 0; n < 40; n++) begin
      tid = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(1, (1 << TW) - 1)) : '0;
      run_req($urandom_range(0, 1) == 1, tid, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_violation();
    test_backpressure();
    test_lockout();
    test_reset_in_capture();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/secure_reg_access_ctrl.md
# secure_reg_access_ctrl

Request sequencer that sits directly upstream of the thread-gated secure register. It accepts thread-tagged read/write requests over a valid/ready handshake and screens them against the thread-0-only policy. Authorized requests become single-cycle access/write strobes to the register; read data and an error flag return over a valid/ready response channel. Repeated unauthorized attempts can lock the port for a fixed interval.

## Interface
- DATA_WIDTH, 32, register data width
- TID_WIDTH, 4, requester thread-id width
- MAX_VIOL, 3, consecutive violations that trigger lockout (≥1)
- LOCK_CYCLES, 16, lockout duration in clk cycles (≥1)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_tid  in  TID_WIDTH  requester thread id
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  request rejected by thread check
- reg_access_en  out  1  access strobe to register
- reg_wr_en  out  1  write strobe to register
- reg_thread_id  out  1  thread flag to register: 0 only for authorized (tid==0) access
- reg_data_in  out  DATA_WIDTH  write data to register
- reg_data_out  in  DATA_WIDTH  register read data, valid one cycle after strobe
- locked  out  1  port in lockout

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP, LOCK.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/tid/wdata.
  - tid==0 -> ISSUE.
  - tid!=0 -> RESP with rsp_err=1, rsp_rdata=0; violation counter +1 (saturates at MAX_VIOL); no register strobes ever issued.
- ISSUE (1 cycle): reg_access_en=1, reg_wr_en=latched write, reg_thread_id=0, reg_data_in=latched wdata. Write -> RESP; read -> CAPTURE.
- CAPTURE (1 cycle): sample reg_data_out into rsp_rdata -> RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready. On handshake: if violation count == MAX_VIOL -> LOCK, else -> IDLE.
- Any authorized request clears the violation counter (at acceptance).
- LOCK: req_ready=0, locked=1, down-counter loaded with LOCK_CYCLES-1 on entry; at 0 -> IDLE and violation counter cleared.
- req_ready=0 in every state except IDLE; only one request outstanding.
- reg_access_en/reg_wr_en high only in ISSUE; reg_thread_id=1 and reg_data_in=0 outside ISSUE.
- Counter widths: $clog2(MAX_VIOL+1) and $clog2(LOCK_CYCLES+1).

## Timing
- Reset values: req_ready=0 during reset, 1 in first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_access_en=0, reg_wr_en=0, reg_thread_id=1, reg_data_in=0, locked=0; state IDLE, both counters 0.
- Acceptance edge = cycle 0. Write: strobe cycle 1, rsp_valid cycle 2. Read: strobe cycle 1, capture cycle 2, rsp_valid cycle 3. Violation: rsp_valid cycle 1.
- rsp_ready held high: next request accepted the cycle after the response handshake (non-locking case).
- Lock entered the cycle after the RESP handshake; locked high for exactly LOCK_CYCLES cycles; req_ready rises the following cycle.
- Reset asserted mid-operation (any state): next edge returns to IDLE with reset values; a pending strobe or response is dropped.

## Configuration
- SECREG_LOCKOUT_EN defined: violation counter, LOCK state and lock timer present as above.
- Undefined: no counter, no LOCK state; RESP always returns to IDLE; locked tied 0. Error responses unchanged.

## Test plan
- Reset, then write tid=0 data 0xDEADBEEF -> reg_access_en=reg_wr_en=1 at cycle 1 with reg_data_in=0xDEADBEEF; rsp_valid cycle 2, rsp_err=0, rsp_rdata=0.
- Read tid=0 with reg_data_out=0xDEADBEEF -> strobe cycle 1 (reg_wr_en=0), rsp_valid cycle 3, rsp_rdata=0xDEADBEEF.
- Write tid=5 -> no strobes at any cycle; rsp_valid cycle 1, rsp_err=1, rsp_rdata=0.
- rsp_ready held low 4 cycles on a read -> rsp_valid and rsp_rdata stable; req_ready=0 throughout.
- (Macro on) 3 consecutive tid=2 requests -> locked=1 for 16 cycles, req_ready=0; then a tid=0 write completes normally. Two violations followed by a tid=0 access then one violation -> no lockout.
- Reset pulsed during CAPTURE -> rsp_valid never asserted, all outputs at reset values, next tid=0 read completes in 3 cycles.
